sat_acc_8bit: RTL and testbench

- Downstream consumer of the 8-bit signed CLA with OVF/UVF detection.
- Takes a stream of 8-bit two's-complement sums plus their ovf/uvf flags over a valid/ready handshake.
- Clamps each flagged sample, then accumulates COUNT samples into a saturating 8-bit signed running sum.
- Presents the block result downstream over a second valid/ready handshake, then restarts from zero.

---
 rtl/sat_acc_pkg.sv | 17 +
 rtl/cla_8bit.sv | 63 ++++++
 rtl/sat_add8.sv | 47 ++++
 rtl/sat_acc_8bit.sv | 147 ++++++++++++++
 tb/tb_sat_acc_8bit.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sat_acc_pkg.sv
// -----------------------------------------------------------------------------
// sat_acc_pkg
// Shared definitions for the saturating sample accumulator:
//   S8_MAX / S8_MIN  - signed 8-bit clamp limits
//   sat_acc_state_t  - accumulator control states (ACCUM, HOLD)
// -----------------------------------------------------------------------------
package sat_acc_pkg;

    localparam logic signed [7:0] S8_MAX = 8'sh7F;
    localparam logic signed [7:0] S8_MIN = 8'sh80;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } sat_acc_state_t;

endpackage

// File: rtl/cla_8bit.sv
// -----------------------------------------------------------------------------
// cla_8bit
// 8-bit two's-complement carry-lookahead adder with signed overflow detect.
// Built from two 4-bit lookahead groups; the low group's carry-out feeds the
// high group.
// Ports:
//   a, b  in  [7:0]  operands (two's complement)
//   cin   in         carry in
//   sum   out [7:0]  raw 8-bit sum (wraps on overflow)
//   ovf   out        positive overflow (both operands >= 0, result < 0)
//   uvf   out        negative overflow (both operands < 0, result >= 0)
// -----------------------------------------------------------------------------
module cla_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       ovf,
    output logic       uvf
);

    // Carries into each bit of a 4-bit group, fully expanded lookahead terms.
    function automatic logic [3:0] cla4_carry(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Carry out of a 4-bit group from group generate/propagate.
    function automatic logic cla4_cout(input logic [3:0] g,
                                       input logic [3:0] p,
                                       input logic       ci);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
    endfunction

    logic [7:0] gen_s;
    logic [7:0] prop_s;
    logic [3:0] carry_lo_s;
    logic [3:0] carry_hi_s;
    logic       carry_mid_s;

    assign gen_s       = a & b;
    assign prop_s      = a ^ b;
    assign carry_lo_s  = cla4_carry(gen_s[3:0], prop_s[3:0], cin);
    assign carry_mid_s = cla4_cout(gen_s[3:0], prop_s[3:0], cin);
    assign carry_hi_s  = cla4_carry(gen_s[7:4], prop_s[7:4], carry_mid_s);

    // Sum bits and signed overflow flags from the operand and result signs.
    always_comb begin
        sum = prop_s ^ {carry_hi_s, carry_lo_s};
        ovf = ~a[7] & ~b[7] &  sum[7];
        uvf =  a[7] &  b[7] & ~sum[7];
    end

endmodule

// File: rtl/sat_add8.sv
// -----------------------------------------------------------------------------
// sat_add8
// Combinational 8-bit signed add that clamps to S8_MAX / S8_MIN on overflow.
// Ports:
//   a, b    in  [7:0]  signed operands
//   result  out [7:0]  saturated signed sum
//   sat     out        high when the result was clamped
// -----------------------------------------------------------------------------
module sat_add8
    import sat_acc_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output logic       sat
);

    logic [7:0] raw_sum_s;
    logic       ovf_s;
    logic       uvf_s;

    cla_8bit u_cla (
        .a   (a),
        .b   (b),
        .cin (1'b0),
        .sum (raw_sum_s),
        .ovf (ovf_s),
        .uvf (uvf_s)
    );

    // Replace a wrapped sum with the limit on the side it overflowed.
    always_comb begin
        result = raw_sum_s;
        sat    = 1'b0;
        if (ovf_s) begin
            result = S8_MAX;
            sat    = 1'b1;
        end else if (uvf_s) begin
            result = S8_MIN;
            sat    = 1'b1;
        end else begin
            result = raw_sum_s;
            sat    = 1'b0;
        end
    end

endmodule

// File: rtl/sat_acc_8bit.sv
// -----------------------------------------------------------------------------
// sat_acc_8bit
// Accepts a stream of 8-bit signed sums with overflow/underflow flags, clamps
// flagged samples, and accumulates COUNT samples into a saturating 8-bit
// running sum. The block result is offered downstream and the accumulator
// restarts from zero.
// Ports:
//   clk        in         clock, rising edge
//   rst        in         synchronous active-high reset
//   in_valid   in         sample valid
//   in_ready   out        sample accepted this cycle (ACCUM state)
//   in_sum     in  [7:0]  signed sample
//   in_ovf     in         sample overflowed positive (clamp to 0x7F)
//   in_uvf     in         sample overflowed negative (clamp to 0x80)
//   out_valid  out        block result available
//   out_ready  in         downstream takes the result
//   out_acc    out [7:0]  saturated block sum
//   out_sat    out        a clamp or saturation happened in this block
//   evt_cnt    out [7:0]  (SAT_ACC_EVENT_CNT_EN only) saturating event count
// Optional feature macro: SAT_ACC_EVENT_CNT_EN
// -----------------------------------------------------------------------------
module sat_acc_8bit
    import sat_acc_pkg::*;
#(
    parameter int COUNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_sum,
    input  logic       in_ovf,
    input  logic       in_uvf,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_acc,
    output logic       out_sat
`ifdef SAT_ACC_EVENT_CNT_EN
    ,
    output logic [7:0] evt_cnt
`endif
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    sat_acc_state_t   state_r;
    logic [7:0]       acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;

    logic [7:0]       x_s;
    logic             clamp_s;
    logic [7:0]       acc_next_s;
    logic             add_sat_s;
    logic             accept_s;

    assign in_ready = (state_r == ACCUM);
    assign accept_s = in_valid & in_ready;

    // Input clamp: ovf wins if both flags are (illegally) high.
    always_comb begin
        x_s     = in_sum;
        clamp_s = 1'b0;
        if (in_ovf) begin
            x_s     = S8_MAX;
            clamp_s = 1'b1;
        end else if (in_uvf) begin
            x_s     = S8_MIN;
            clamp_s = 1'b1;
        end else begin
            x_s     = in_sum;
            clamp_s = 1'b0;
        end
    end

    sat_add8 u_sat_add (
        .a      (acc_r),
        .b      (x_s),
        .result (acc_next_s),
        .sat    (add_sat_s)
    );

    // Accumulate / hand off control FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ACCUM;
            acc_r     <= 8'h00;
            cnt_r     <= '0;
            sat_r     <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= 8'h00;
            out_sat   <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        if (cnt_r == LAST_CNT) begin
                            out_acc   <= acc_next_s;
                            out_sat   <= sat_r | clamp_s | add_sat_s;
                            out_valid <= 1'b1;
                            state_r   <= HOLD;
                            acc_r     <= 8'h00;
                            cnt_r     <= '0;
                            sat_r     <= 1'b0;
                        end else begin
                            acc_r <= acc_next_s;
                            cnt_r <= cnt_r + CNT_W'(1);
                            sat_r <= sat_r | clamp_s | add_sat_s;
                        end
                    end
                end
                HOLD: begin
                    // Result is frozen until downstream takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= ACCUM;
                    end
                end
                default: begin
                    state_r   <= ACCUM;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SAT_ACC_EVENT_CNT_EN
    logic [7:0] evt_cnt_r;
    logic [8:0] evt_sum_s;

    assign evt_sum_s = {1'b0, evt_cnt_r} + {8'h00, clamp_s} + {8'h00, add_sat_s};
    assign evt_cnt   = evt_cnt_r;

    // Free-running event count, saturating at 0xFF, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt_r <= 8'h00;
        end else if (accept_s) begin
            evt_cnt_r <= evt_sum_s[8] ? 8'hFF : evt_sum_s[7:0];
        end else begin
            evt_cnt_r <= evt_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_sat_acc_8bit.sv
// Self-checking bench for sat_acc_8bit (COUNT=4). Inputs change and outputs
// are sampled on the falling clock edge.
module tb_sat_acc_8bit;

    localparam int COUNT = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_sum;
    logic       in_ovf;
    logic       in_uvf;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_acc;
    logic       out_sat;
`ifdef SAT_ACC_EVENT_CNT_EN
    logic [7:0] evt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integer arithmetic on the sample rules).
    int         m_acc = 0;
    int         m_cnt = 0;
    bit         m_sat = 1'b0;
    int         m_evt = 0;
    int         exp_acc = 0;
    bit         exp_sat = 1'b0;
    logic [7:0] exp_b;

    sat_acc_8bit #(.COUNT(COUNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_ovf    (in_ovf),
        .in_uvf    (in_uvf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_sat   (out_sat)
`ifdef SAT_ACC_EVENT_CNT_EN
        ,
        .evt_cnt   (evt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc = 0;
        m_cnt = 0;
        m_sat = 1'b0;
        m_evt = 0;
    endtask

    task automatic model_accept(input logic [7:0] s, input logic ovf, input logic uvf);
        int x;
        int t;
        int ev;
        ev = 0;
        if (ovf) x = 127;
        else if (uvf) x = -128;
        else x = int'($signed(s));
        if (ovf || uvf) begin
            m_sat = 1'b1;
            ev++;
        end
        t = m_acc + x;
        if (t > 127) begin
            t = 127;
            m_sat = 1'b1;
            ev++;
        end else if (t < -128) begin
            t = -128;
            m_sat = 1'b1;
            ev++;
        end
        m_evt = (m_evt + ev > 255) ? 255 : m_evt + ev;
        m_cnt++;
        if (m_cnt == COUNT) begin
            exp_acc = t;
            exp_sat = m_sat;
            exp_b   = exp_acc[7:0];
            m_acc   = 0;
            m_cnt   = 0;
            m_sat   = 1'b0;
        end else begin
            m_acc = t;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sum   = 8'($urandom);
        in_ovf   = 1'b0;
        in_uvf   = 1'b0;
        @(negedge clk);
    endtask

    // Present one sample, wait (bounded) for ready, and let it be accepted.
    task automatic send(input logic [7:0] s, input logic ovf, input logic uvf);
        int n;
        in_valid = 1'b1;
        in_sum   = s;
        in_ovf   = ovf;
        in_uvf   = uvf;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        model_accept(s, ovf, uvf);
    endtask

    // Send COUNT samples with random bubbles and check the block result.
    task automatic run_block(input logic [31:0] sums, input logic [3:0] ovfs,
                             input logic [3:0] uvfs, input int bub);
        for (int i = 0; i < COUNT; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL early_valid sample %0d out_valid=%b required 0", i, out_valid);
            end
            repeat ($urandom_range(0, bub)) idle();
            send(sums[8*i +: 8], ovfs[i], uvfs[i]);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL block_valid out_valid=%b required 1", out_valid);
        end
        checks++;
        if (out_acc !== exp_b) begin
            errors++;
            $display("FAIL block_acc out_acc=%h required %h", out_acc, exp_b);
        end
        checks++;
        if (out_sat !== exp_sat) begin
            errors++;
            $display("FAIL block_sat out_sat=%b required %b", out_sat, exp_sat);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready in_ready=%b required 0", in_ready);
        end
    endtask

    // Keep out_ready low for 'hold' cycles, then complete the handshake.
    task automatic handshake(input int hold);
        in_valid = 1'b0;
        repeat (hold) begin
            out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_acc !== exp_b) begin
                errors++;
                $display("FAIL hold_stable valid=%b acc=%h required 1/%h", out_valid, out_acc, exp_b);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release valid=%b ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        if (out_acc !== exp_b) begin
            errors++;
            $display("FAIL acc_kept out_acc=%h required %h", out_acc, exp_b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || out_acc !== 8'h00 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state valid=%b acc=%h sat=%b ready=%b required 0/00/0/1",
                     out_valid, out_acc, out_sat, in_ready);
        end
    endtask

    task automatic test_basic_sum();
        run_block({8'd40, 8'd30, 8'd20, 8'd10}, 4'b0000, 4'b0000, 0);
        checks++;
        if (out_acc !== 8'h64 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum acc=%h sat=%b required 64/0", out_acc, out_sat);
        end
        handshake(0);
    endtask

    task automatic test_add_saturation();
        run_block({8'd0, 8'hCE, 8'd100, 8'd100}, 4'b0000, 4'b0000, 0);
        checks++;
        if (out_acc !== 8'h4D || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL add_sat acc=%h sat=%b required 4d/1", out_acc, out_sat);
        end
        handshake(1);
    endtask

    task automatic test_clamp();
        run_block({8'hFF, 8'hFF, 8'hFF, 8'h10}, 4'b0000, 4'b0001, 0);
        checks++;
        if (out_acc !== 8'h80 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL uvf_clamp acc=%h sat=%b required 80/1", out_acc, out_sat);
        end
        handshake(0);
        // Both flags high on the first sample: treated as 0x7F.
        run_block({8'h00, 8'h00, 8'h00, 8'h00}, 4'b0001, 4'b0001, 0);
        checks++;
        if (out_acc !== 8'h7F || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL both_flags acc=%h sat=%b required 7f/1", out_acc, out_sat);
        end
        handshake(0);
    endtask

    task automatic test_hold();
        logic [7:0] tog;
        run_block(32'($urandom), 4'b0000, 4'b0000, 0);
        tog = 8'h55;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_sum    = tog;
            tog       = ~tog;
            out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_acc !== exp_b || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_ignore valid=%b acc=%h ready=%b required 1/%h/0",
                         out_valid, out_acc, in_ready, exp_b);
            end
        end
        handshake(0);
        run_block({8'd1, 8'd1, 8'd1, 8'd1}, 4'b0000, 4'b0000, 0);
        checks++;
        if (out_acc !== 8'd4) begin
            errors++;
            $display("FAIL after_hold acc=%h required 04", out_acc);
        end
        handshake(0);
    endtask

    task automatic test_mid_block_reset();
        send(8'd50, 1'b0, 1'b1);
        send(8'd7, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || out_acc !== 8'h00 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset valid=%b acc=%h sat=%b ready=%b required 0/00/0/1",
                     out_valid, out_acc, out_sat, in_ready);
        end
        run_block({8'd1, 8'd1, 8'd1, 8'd1}, 4'b0000, 4'b0000, 0);
        checks++;
        if (out_acc !== 8'd4 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL post_reset acc=%h sat=%b required 04/0", out_acc, out_sat);
        end
        handshake(0);
    endtask

    task automatic test_bubbles();
        send(8'd5, 1'b0, 1'b0);
        idle();
        idle();
        send(8'd5, 1'b0, 1'b0);
        idle();
        send(8'd5, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_count out_valid=%b required 0", out_valid);
        end
        send(8'd5, 1'b0, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_acc !== 8'd20 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL bubbles valid=%b acc=%h sat=%b required 1/14/0", out_valid, out_acc, out_sat);
        end
        handshake(2);
    endtask

    task automatic test_random();
        logic [3:0] ovfs;
        logic [3:0] uvfs;
        int r;
        for (int b = 0; b < 25; b++) begin
            ovfs = 4'b0000;
            uvfs = 4'b0000;
            for (int i = 0; i < COUNT; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0) ovfs[i] = 1'b1;
                else if (r == 1) uvfs[i] = 1'b1;
                else if (r == 2) begin
                    ovfs[i] = 1'b1;
                    uvfs[i] = 1'b1;
                end
            end
            run_block(32'($urandom), ovfs, uvfs, 2);
            handshake($urandom_range(0, 3));
        end
`ifdef SAT_ACC_EVENT_CNT_EN
        checks++;
        if (evt_cnt !== 8'(m_evt)) begin
            errors++;
            $display("FAIL evt_cnt got %h required %h", evt_cnt, 8'(m_evt));
        end
`endif
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = 8'h00;
        in_ovf    = 1'b0;
        in_uvf    = 1'b0;
        out_ready = 1'b0;
        exp_b     = 8'h00;
        test_reset();
        test_basic_sum();
        test_add_saturation();
        test_clamp();
        test_hold();
        test_mid_block_reset();
        test_bubbles();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
